lfsr_seed_sequencer: RTL

- Sequential stage directly upstream of the combinational LFSR segment randomiser.
- Holds the RNDSIZE-bit LFSR state and steps it with the same polynomial: feedback = s[RNDSIZE-1]^s[3]^s[2]^s[0]; next = {s[RNDSIZE-2:0], feedback}.
- Presents seed, probability and count (frame index) to the randomiser with a valid/ready handshake.
- Runs a warm-up burst after each reseed so that consecutive frames are decorrelated.

---
 rtl/lfsr_seed_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lfsr_seed_sequencer.sv
// Seed sequencer for the LFSR segment randomiser: holds and steps the LFSR state,
// runs a warm-up burst after every reseed and hands out seed/probability/frame index.
module lfsr_seed_sequencer #(
  parameter int                 RNDSIZE      = 70,
  parameter int                 COUNTERSIZE  = 4,
  parameter int                 COUNT_MAX    = 9,
  parameter int                 WARMUP_STEPS = 16,
  parameter logic [RNDSIZE-1:0] INIT_SEED    = RNDSIZE'(1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [RNDSIZE-1:0]     load_seed,
  input  logic [COUNTERSIZE-1:0] load_prob,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RNDSIZE-1:0]     seed,
  output logic [COUNTERSIZE-1:0] probability,
  output logic [COUNTERSIZE-1:0] count
);

  localparam int WW = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Same polynomial as the downstream combinational randomiser.
  function automatic logic [RNDSIZE-1:0] lfsr_step(input logic [RNDSIZE-1:0] s);
    logic fb;
    fb = s[RNDSIZE-1] ^ s[3] ^ s[2] ^ s[0];
    return {s[RNDSIZE-2:0], fb};
  endfunction

  state_e                 state_q, state_d;
  logic [RNDSIZE-1:0]     seed_q, seed_d;
  logic [COUNTERSIZE-1:0] prob_q, prob_d;
  logic [COUNTERSIZE-1:0] count_q, count_d;
  logic [WW-1:0]          warm_q, warm_d;
  logic                   out_valid_q, out_valid_d;
  logic                   load_ready_q, load_ready_d;
  logic                   load_acc_s;
  logic                   hs_s;

  assign load_acc_s = load_valid & load_ready_q;
  assign hs_s       = out_valid_q & out_ready;

  // Next-state logic; a load always wins over a concurrent output handshake.
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    prob_d       = prob_q;
    count_d      = count_q;
    warm_d       = warm_q;
    out_valid_d  = 1'b0;
    load_ready_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (load_acc_s) begin
          seed_d  = (load_seed == '0) ? INIT_SEED : load_seed;
          prob_d  = load_prob;
          count_d = '0;
          warm_d  = '0;
          state_d = (WARMUP_STEPS > 0) ? ST_WARMUP : ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        seed_d = lfsr_step(seed_q);
        warm_d = warm_q + WW'(1);
        if (warm_q == WW'(WARMUP_STEPS - 1)) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_WARMUP;
        end
      end
      ST_ACTIVE: begin
        if (load_acc_s) begin
          seed_d  = (load_seed == '0) ? INIT_SEED : load_seed;
          prob_d  = load_prob;
          count_d = '0;
          warm_d  = '0;
          state_d = (WARMUP_STEPS > 0) ? ST_WARMUP : ST_ACTIVE;
        end else if (hs_s) begin
          seed_d  = lfsr_step(seed_q);
          count_d = (count_q == COUNTERSIZE'(COUNT_MAX)) ? '0 : count_q + COUNTERSIZE'(1);
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        seed_d  = INIT_SEED;
        prob_d  = '0;
        count_d = '0;
        warm_d  = '0;
      end
    endcase
    // Handshake flags are derived from the next state so they come straight off flops.
    out_valid_d  = (state_d == ST_ACTIVE);
    load_ready_d = (state_d != ST_WARMUP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      seed_q       <= INIT_SEED;
      prob_q       <= '0;
      count_q      <= '0;
      warm_q       <= '0;
      out_valid_q  <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      prob_q       <= prob_d;
      count_q      <= count_d;
      warm_q       <= warm_d;
      out_valid_q  <= out_valid_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign seed        = seed_q;
  assign probability = prob_q;
  assign count       = count_q;
  assign out_valid   = out_valid_q;
  assign load_ready  = load_ready_q;

endmodule
